seq_det_prog: RTL

Runtime-programmable serial sequence detector, the parametrised successor to the team's fixed-pattern detectors. It accepts one serial bit per qualified cycle and matches against a pattern of 1..MAX_LEN bits loaded at run time, with selectable overlapping or non-overlapping detection. It pulses a one-cycle detect flag per match and optionally keeps a saturating match count. It sits between a serial front end (deserialiser or sync-word hunter) and downstream framing control.

---
 rtl/seq_det_pkg.sv | 6 +
 rtl/seq_det_sat_cnt.sv | 14 +
 rtl/seq_det_prog.sv | 85 ++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding and default sizes for the programmable sequence detector
package seq_det_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, HUNT = 2'd2} state_t;
  localparam int MAX_LEN_D = 16;
  localparam int CNT_W_D   = 8;
endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: generic saturating up-counter
module seq_det_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog: runtime-programmable serial sequence detector, overlapping or non-overlapping
// SEQDET_MATCH_CNT_EN builds the saturating match counter; otherwise match_cnt_o is tied to 0.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_D,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = CNT_W_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x_i,
  input  logic               x_vld_i,
  input  logic               cfg_ld_i,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
  output logic               det_o,
  output logic               cfg_err_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic [1:0]         state_o
);
  state_t             r_state;
  logic [MAX_LEN-1:0] r_pat, r_hist;
  logic [LEN_W-1:0]   r_len, r_fill;
  logic               r_ovl, r_det, r_err;
  logic [MAX_LEN-1:0] w_hist_n, w_mask;
  logic [LEN_W-1:0]   w_fill_n;
  logic               w_len_ok, w_active, w_accept, w_match;
  assign w_len_ok = (len_i != '0) && (len_i <= LEN_W'(MAX_LEN));
  assign w_active = (r_state == FILL) || (r_state == HUNT);
  assign w_accept = x_vld_i && !cfg_ld_i && w_active;
  assign w_hist_n = {r_hist[MAX_LEN-2:0], x_i};
  assign w_fill_n = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;
  // only the low r_len history bits take part in the compare
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) w_mask[i] = (i < int'(r_len));
  end
  assign w_match = w_accept && (w_fill_n >= r_len) && (((w_hist_n ^ r_pat) & w_mask) == '0);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_det   <= 1'b0;
      r_err   <= 1'b0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= '0;
      r_len   <= '0;
      r_ovl   <= 1'b0;
    end else begin
      r_det <= 1'b0;
      r_err <= 1'b0;
      if (cfg_ld_i) begin
        r_pat   <= pat_i;
        r_ovl   <= overlap_i;
        r_hist  <= '0;
        r_fill  <= '0;
        r_len   <= w_len_ok ? len_i : '0;
        r_state <= w_len_ok ? FILL : IDLE;
        r_err   <= !w_len_ok;
      end else if (w_accept) begin
        r_hist  <= w_hist_n;
        r_det   <= w_match;
        r_fill  <= (w_match && !r_ovl) ? '0 : w_fill_n;
        r_state <= (w_match && !r_ovl) ? FILL : (w_fill_n >= r_len) ? HUNT : FILL;
      end else if (!w_active) begin
        r_state <= IDLE;
      end
    end
  end
  assign det_o     = r_det;
  assign cfg_err_o = r_err;
  assign state_o   = r_state;
`ifdef SEQDET_MATCH_CNT_EN
  seq_det_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (w_match),
    .cnt  (match_cnt_o)
  );
`else
  assign match_cnt_o = '0;
`endif
endmodule
